// File: rtl/full_subtractor_reg_pkg.sv
// Shared constants for the registered full subtractor.
package full_subtractor_reg_pkg;
  localparam int   FSR_MAX_WIDTH = 64;
  localparam logic FSR_RST_VAL   = 1'b0;
endpackage

// File: rtl/full_subtractor_bit.sv
// 1-bit full subtractor cell: diff = a ^ b ^ bin, borrow-out per bit.
// Purely combinational, zero latency, no backpressure.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/full_subtractor_reg.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bout,diff} = a - b - bin.
// Latency 1 cycle; no backpressure, one result per valid input.
module full_subtractor_reg
  import full_subtractor_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  logic [WIDTH:0]   brw;
  logic [WIDTH-1:0] diff_c;

  assign brw[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_subtractor_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (brw[i]),
      .diff (diff_c[i]),
      .bout (brw[i+1])
    );
  end

  // Result registers load only on valid, so idle-cycle input garbage never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= {WIDTH{FSR_RST_VAL}};
      bout      <= FSR_RST_VAL;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff <= diff_c;
        bout <= brw[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_full_subtractor_reg.sv
// Scoreboard bench for full_subtractor_reg at WIDTH=1 and WIDTH=8.
module tb_full_subtractor_reg;
  typedef struct {
    logic [8:0] v;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       out_valid1, diff1, bout1;
  logic       in_valid8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       out_valid8, bout8;
  logic [7:0] diff8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q8[$];
  exp_t e1, e8;

  full_subtractor_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1), .bin(bin1),
    .out_valid(out_valid1), .diff(diff1), .bout(bout1)
  );

  full_subtractor_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(out_valid8), .diff(diff8), .bout(bout8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send1(input logic a, input logic b, input logic bi, input logic [1:0] exp);
    exp_t e;
    @(posedge clk); #1;
    in_valid1 = 1'b1; a1 = a; b1 = b; bin1 = bi;
    e.v = {7'd0, exp}; e.due = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic [8:0] exp);
    exp_t e;
    @(posedge clk); #1;
    in_valid8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
    e.v = exp; e.due = cyc + 1;
    q8.push_back(e);
  endtask

  task automatic idle_all();
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_valid8 = 1'b0;
  endtask

  // Monitors: pop on every presented result, checking value and arrival cycle.
  always @(negedge clk) begin
    if (out_valid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL w1_unexpected actual=%0h required=none", {bout1, diff1});
      end else begin
        e1 = q1.pop_front();
        chk("w1_result", 64'({bout1, diff1}), 64'(e1.v));
        chk("w1_latency", 64'(cyc), 64'(e1.due));
      end
    end
    if (out_valid8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_unexpected actual=%0h required=none", {bout8, diff8});
      end else begin
        e8 = q8.pop_front();
        chk("w8_result", 64'({bout8, diff8}), 64'(e8.v));
        chk("w8_latency", 64'(cyc), 64'(e8.due));
      end
    end
  end

  logic [2:0] vec [8];
  logic [1:0] res [8];
  logic [7:0] ra, rb;
  logic       rbi;
  logic [8:0] rexp;

  initial begin
    vec[0] = 3'b000; res[0] = 2'b00;
    vec[1] = 3'b001; res[1] = 2'b11;
    vec[2] = 3'b010; res[2] = 2'b11;
    vec[3] = 3'b011; res[3] = 2'b10;
    vec[4] = 3'b100; res[4] = 2'b01;
    vec[5] = 3'b101; res[5] = 2'b00;
    vec[6] = 3'b110; res[6] = 2'b00;
    vec[7] = 3'b111; res[7] = 2'b11;

    // Reset state
    #12;
    chk("rst_ov1", 64'(out_valid1), 64'(0));
    chk("rst_d1", 64'({bout1, diff1}), 64'(0));
    chk("rst_ov8", 64'(out_valid8), 64'(0));
    chk("rst_d8", 64'({bout8, diff8}), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // WIDTH=1 exhaustive, back-to-back
    for (int i = 0; i < 8; i++) send1(vec[i][2], vec[i][1], vec[i][0], res[i]);
    idle_all();

    // Asynchronous reset between edges while holding a valid diff=1
    @(negedge clk); #2;
    chk("pre_rst_ov", 64'(out_valid1), 64'(1));
    chk("pre_rst_diff", 64'(diff1), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_ov", 64'(out_valid1), 64'(0));
    chk("async_rst_diff", 64'(diff1), 64'(0));
    chk("async_rst_bout", 64'(bout1), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    send1(1'b1, 1'b0, 1'b0, 2'b01);

    // Hold with garbage inputs while idle
    send1(1'b0, 1'b1, 1'b1, 2'b10);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      if (k == 2) begin a1 = 1'bx; b1 = 1'bx; bin1 = 1'bx; end
      else begin a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom); end
      @(negedge clk); #1;
      chk("hold_diff", 64'(diff1), 64'(0));
      chk("hold_bout", 64'(bout1), 64'(1));
      if (k > 0) chk("hold_ov", 64'(out_valid1), 64'(0));
    end

    // WIDTH=8 directed boundaries
    send8(8'h00, 8'hFF, 1'b1, {1'b1, 8'h00});
    send8(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h1E});
    send8(8'h80, 8'h00, 1'b1, {1'b0, 8'h7F});
    send8(8'h00, 8'h00, 1'b1, {1'b1, 8'hFF});
    send8(8'h5A, 8'h5A, 1'b0, {1'b0, 8'h00});
    send8(8'hFF, 8'h00, 1'b0, {1'b0, 8'hFF});
    send8(8'h01, 8'h01, 1'b1, {1'b1, 8'hFF});
    idle_all();
    idle_all();

    // WIDTH=8 random, back-to-back
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      rexp = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      send8(ra, rb, rbi, rexp);
    end
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    chk("w1_drain", 64'(q1.size()), 64'(0));
    chk("w8_drain", 64'(q8.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_subtractor_reg.md
Name: full_subtractor_reg

Overview:
- Registered full subtractor: computes diff = a - b - bin with borrow-out over a WIDTH-bit ripple-borrow chain.
- Result is captured in an output register one clock after a valid input.
- WIDTH=1 is the basic 1-bit full subtractor cell.
- Used as a leaf arithmetic block in datapaths that need a pipelined subtract-with-borrow.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk      input   1      rising-edge clock.
- rst_n    input   1      asynchronous active-low reset.
- in_valid input   1      a/b/bin qualify this cycle.
- a        input   WIDTH  minuend.
- b        input   WIDTH  subtrahend.
- bin      input   1      borrow-in, applied to bit 0.
- out_valid output 1      diff/bout hold a fresh result.
- diff     output  WIDTH  registered difference bits.
- bout     output  1      registered borrow-out from the MSB.

Behaviour:
- Per-bit cell i, with borrow b_i:
  - diff_i = a_i ^ b_i ^ b_i_in
  - borrow_out_i = (~a_i & b_i) | (~(a_i ^ b_i) & b_i_in)
  - Bit 0 borrow-in = bin; bit i+1 borrow-in = borrow_out_i; bout = borrow_out of bit WIDTH-1.
- Arithmetic equivalence: {bout, diff} = ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1). bout=1 exactly when a < b + bin (unsigned).
- Reset (rst_n low, asynchronous assert, any time including mid-operation): diff=0, bout=0, out_valid=0 immediately. Deassertion is sampled on clk.
- Latency is 1 cycle:
  - On a rising clk edge with in_valid=1: diff/bout load the combinational result of the current a/b/bin, and out_valid=1.
  - On an edge with in_valid=0: diff/bout hold their previous values and out_valid=0.
- No backpressure. Back-to-back valid inputs give one result per cycle.
- a/b/bin are don't-care when in_valid=0. X on inputs while in_valid=0 must not corrupt held outputs.
- Boundaries:
  - a=b, bin=0 -> diff=0, bout=0.
  - a=0, b=all-ones, bin=1 -> diff=0, bout=1 (full wrap).
  - a=all-ones, b=0, bin=0 -> diff=all-ones, bout=0.
- Combinational path from inputs to register only. Outputs are driven solely by flops (no input-to-output combinational path).

Decomposition:
- No shared package needed. A RESET value constant for diff/bout (0) may live in the team's common arithmetic package if one exists.
- One sub-module: full_subtractor_bit, a purely combinational 1-bit cell (a, b, bin -> diff, bout). It is instantiated WIDTH times via a generate loop to form the ripple-borrow chain.
- The top module holds the chain plus the output/valid registers.

Test Plan:
- WIDTH=1 exhaustive, one vector per cycle with in_valid=1. (a,b,bin) -> (diff,bout) one cycle later:
  - 000->0,0; 001->1,1; 010->1,1; 011->0,1
  - 100->1,0; 101->0,0; 110->0,0; 111->1,1
- Reset: drive rst_n=0 between clk edges while out_valid=1, diff=1 -> diff=0, bout=0, out_valid=0 immediately. After release, the first valid vector 100 yields diff=1, bout=0 next cycle.
- Hold: valid 011 then in_valid=0 for 3 cycles with random a/b/bin -> diff=0, bout=1 stays stable and out_valid=0 after the first cycle.
- WIDTH=8 wrap: a=8'h00, b=8'hFF, bin=1 -> diff=8'h00, bout=1. Then a=8'h5A, b=8'h3C, bin=0 -> diff=8'h1E, bout=0.
- WIDTH=8 borrow propagation: a=8'h80, b=8'h00, bin=1 -> diff=8'h7F, bout=0. Then a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
- Random: 1000 back-to-back valid vectors at WIDTH=8 checked against a scoreboard using the a - b - bin equivalence, with 1-cycle latency and out_valid asserted every cycle.
